iua_capture_ctrl: RTL

Capture sequencer for the analyzer's raw USB line samples in the clk_samp domain. It packs 2-bit {dp,dn} samples into bytes and drives a circular sample-buffer write port. It runs pre-fill, arm, trigger and post-trigger phases, then reports the window (start address, length, trigger position) to the readout/UART side. It is configured and commanded by the host command decoder through a synchronized pulse/level interface.

---
 rtl/iua_capture_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/iua_capture_ctrl.sv
// Capture sequencer: packs {dp,dn} line samples into bytes and writes them into a ring.
// Runs the fill, arm, trigger and post phases, then reports the captured window.
module iua_capture_ctrl #(
   parameter int AW = 11
) (
   input  logic          clk_samp,
   input  logic          rst,
   input  logic          in_dp,
   input  logic          in_dn,
   input  logic          in_valid,
   input  logic          cmd_arm,
   input  logic          cmd_abort,
   input  logic          trig_force,
   input  logic [AW-1:0] cfg_pre,
   input  logic [AW:0]   cfg_post,
   input  logic [1:0]    cfg_mode,
   output logic [AW-1:0] mem_waddr,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   output logic          stat_busy,
   output logic          stat_armed,
   output logic          stat_triggered,
   output logic          stat_done,
   output logic [AW-1:0] trig_addr,
   output logic [1:0]    trig_phase,
   output logic [AW-1:0] rd_start,
   output logic [AW:0]   rd_len
);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE
   } state_t;

   localparam logic [AW-1:0] ONE_A = AW'(1);
   localparam logic [AW:0]   ONE_L = (AW+1)'(1);

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0]    pack_cnt_q, pack_cnt_d;
   logic [5:0]    pack_q, pack_d;
   logic [1:0]    prev_q, prev_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] pre_q, pre_d;
   logic [AW:0]   post_q, post_d;
   logic [1:0]    mode_q, mode_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_waddr_q, mem_waddr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic [AW-1:0] trig_addr_q, trig_addr_d;
   logic [1:0]    trig_phase_q, trig_phase_d;
   logic [AW-1:0] rd_start_q, rd_start_d;
   logic [AW:0]   rd_len_q, rd_len_d;

   logic [1:0]    smp;
   logic          busy, take, word_done, cond, trig_hit, arm_ok;
   logic [AW:0]   room, post_min, post_eff;

   assign smp       = {in_dp, in_dn};
   assign busy      = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
   assign take      = busy && in_valid;
   assign word_done = take && (pack_cnt_q == 2'd3);
   assign arm_ok    = cmd_arm && !cmd_abort && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Post length is at least one word and never lets the window exceed the ring.
   assign room      = {1'b1, {AW{1'b0}}} - {1'b0, cfg_pre};
   assign post_min  = (cfg_post == '0) ? ONE_L : cfg_post;
   assign post_eff  = (post_min > room) ? room : post_min;

   // Trigger condition for the current sample against the previous valid one.
   always_comb begin
      cond = 1'b0;
      case (mode_q)
         2'd0:    cond = (smp != prev_q);
         2'd1:    cond = (smp == 2'b00) && (prev_q != 2'b00);
         2'd2:    cond = 1'b1;
         default: cond = 1'b0;
      endcase
   end

   assign trig_hit = (state_q == S_ARMED) && in_valid && (trig_force || cond);

   // Next-state logic: packing, phase sequencing, arm and abort.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      pack_cnt_d   = pack_cnt_q;
      pack_d       = pack_q;
      prev_d       = prev_q;
      cnt_d        = cnt_q;
      pre_d        = pre_q;
      post_d       = post_q;
      mode_d       = mode_q;
      mem_we_d     = 1'b0;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      trig_addr_d  = trig_addr_q;
      trig_phase_d = trig_phase_q;
      rd_start_d   = rd_start_q;
      rd_len_d     = rd_len_q;

      if (take) begin
         pack_cnt_d = pack_cnt_q + 2'd1;
         prev_d     = smp;
         case (pack_cnt_q)
            2'd0: pack_d[1:0] = smp;
            2'd1: pack_d[3:2] = smp;
            2'd2: pack_d[5:4] = smp;
            default: begin
               mem_we_d    = 1'b1;
               mem_waddr_d = wr_ptr_q;
               mem_wdata_d = {smp, pack_q};
               wr_ptr_d    = wr_ptr_q + ONE_A;
               cnt_d       = cnt_q + ONE_L;
            end
         endcase
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm_ok) begin
               pre_d      = cfg_pre;
               post_d     = post_eff;
               mode_d     = cfg_mode;
               wr_ptr_d   = '0;
               pack_cnt_d = 2'd0;
               cnt_d      = '0;
               prev_d     = 2'b01;
               state_d    = (cfg_pre != '0) ? S_FILL : S_ARMED;
            end
         end
         S_FILL: begin
            if (mem_we_q && (cnt_q == {1'b0, pre_q}))
               state_d = S_ARMED;
         end
         S_ARMED: begin
            if (trig_hit) begin
               state_d      = S_POST;
               trig_addr_d  = wr_ptr_q;
               trig_phase_d = pack_cnt_q;
               cnt_d        = word_done ? ONE_L : '0;
            end
         end
         S_POST: begin
            if (mem_we_q && (cnt_q == post_q)) begin
               state_d    = S_DONE;
               rd_start_d = trig_addr_q - pre_q;
               rd_len_d   = {1'b0, pre_q} + post_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (cmd_abort) begin
         state_d      = S_IDLE;
         mem_we_d     = 1'b0;
         pack_cnt_d   = 2'd0;
         trig_addr_d  = trig_addr_q;
         trig_phase_d = trig_phase_q;
         rd_start_d   = rd_start_q;
         rd_len_d     = rd_len_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_samp) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         pack_cnt_q   <= 2'd0;
         pack_q       <= '0;
         prev_q       <= 2'b00;
         cnt_q        <= '0;
         pre_q        <= '0;
         post_q       <= '0;
         mode_q       <= 2'd0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         trig_addr_q  <= '0;
         trig_phase_q <= 2'd0;
         rd_start_q   <= '0;
         rd_len_q     <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         pack_cnt_q   <= pack_cnt_d;
         pack_q       <= pack_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         pre_q        <= pre_d;
         post_q       <= post_d;
         mode_q       <= mode_d;
         mem_we_q     <= mem_we_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         trig_addr_q  <= trig_addr_d;
         trig_phase_q <= trig_phase_d;
         rd_start_q   <= rd_start_d;
         rd_len_q     <= rd_len_d;
      end
   end

   assign mem_we         = mem_we_q;
   assign mem_waddr      = mem_waddr_q;
   assign mem_wdata      = mem_wdata_q;
   assign stat_busy      = busy;
   assign stat_armed     = (state_q == S_ARMED);
   assign stat_triggered = (state_q == S_POST) || (state_q == S_DONE);
   assign stat_done      = (state_q == S_DONE);
   assign trig_addr      = trig_addr_q;
   assign trig_phase     = trig_phase_q;
   assign rd_start       = rd_start_q;
   assign rd_len         = rd_len_q;

endmodule
